// File: rtl/seq_control.sv
// Multi-cycle instruction sequencer: fetch/decode/execute/memory/writeback control,
// shared memory-port handshake with timeout, latched opcode and per-phase strobes.
module seq_control #(
  parameter int IW      = 16,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  input  logic          mem_ack,
  input  logic [IW-1:0] instr_in,
  input  logic          zero_flag,
  output logic          mem_req,
  output logic          mem_we,
  output logic          mem_addr_sel,
  output logic          ir_load,
  output logic          pc_inc,
  output logic          pc_load,
  output logic          mdr_load,
  output logic          alu_en,
  output logic          regwrite_en,
  output logic [3:0]    op_q,
  output logic          err,
  output logic [2:0]    state_q
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd7
  } state_e;

  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  state_e     fsm_q, fsm_d;
  logic [3:0] op_d;
  logic [7:0] wait_q, wait_d;
  logic       err_q, err_d;

  logic is_alu, is_lw, is_store, is_bez, is_nop;

  // Opcode classes; anything outside the defined set behaves as NOP.
  assign is_alu   = (op_q >= 4'd1) && (op_q <= 4'd5);
  assign is_lw    = (op_q == 4'd8);
  assign is_store = (op_q == 4'd9) || (op_q == 4'd10);
  assign is_bez   = (op_q == 4'd11);
  assign is_nop   = !(is_alu || is_lw || is_store || is_bez);

  logic unused_instr_bits;
  assign unused_instr_bits = ^instr_in[IW-5:0];

  assign state_q = fsm_q;
  assign err     = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q  <= S_IDLE;
      op_q   <= 4'd0;
      wait_q <= 8'd0;
      err_q  <= 1'b0;
    end else begin
      fsm_q  <= fsm_d;
      op_q   <= op_d;
      wait_q <= wait_d;
      err_q  <= err_d;
    end
  end

  always_comb begin
    fsm_d        = fsm_q;
    op_d         = op_q;
    wait_d       = 8'd0;
    err_d        = err_q;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_load      = 1'b0;
    pc_inc       = 1'b0;
    pc_load      = 1'b0;
    mdr_load     = 1'b0;
    alu_en       = 1'b0;
    regwrite_en  = 1'b0;
    unique case (fsm_q)
      S_IDLE: begin
        if (run) fsm_d = S_FETCH;
      end
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_load = 1'b1;
          pc_inc  = 1'b1;
          op_d    = instr_in[IW-1 -: 4];
          fsm_d   = S_DECODE;
        end else if (wait_q == LAST_WAIT) begin
          fsm_d = S_HALT;
          err_d = 1'b1;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_DECODE: begin
        fsm_d = is_nop ? S_FETCH : S_EXEC;
      end
      S_EXEC: begin
        alu_en = !is_nop;
        if (is_alu) begin
          fsm_d = S_WB;
        end else if (is_lw || is_store) begin
          fsm_d = S_MEM;
        end else begin
          pc_load = is_bez && zero_flag;
          fsm_d   = S_FETCH;
        end
      end
      S_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = is_store;
        // Ack in the expiry cycle takes priority over the timeout.
        if (mem_ack) begin
          mdr_load = is_lw;
          fsm_d    = is_lw ? S_WB : S_FETCH;
        end else if (wait_q == LAST_WAIT) begin
          fsm_d = S_HALT;
          err_d = 1'b1;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_WB: begin
        regwrite_en = 1'b1;
        fsm_d       = S_FETCH;
      end
      S_HALT: begin
        fsm_d = S_HALT;
      end
      default: begin
        fsm_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_seq_control.sv
// Randomized self-checking bench for seq_control: expected per-cycle output traces are
// built from each instruction's phase list (fetch waits, decode, exec, mem waits, wb).
module tb_seq_control;

  localparam int IW = 16;
  localparam int TO = 4;

  logic          clk, rst, run, mem_ack, zero_flag;
  logic [IW-1:0] instr_in;
  logic          mem_req, mem_we, mem_addr_sel, ir_load, pc_inc, pc_load;
  logic          mdr_load, alu_en, regwrite_en, err;
  logic [3:0]    op_q;
  logic [2:0]    state_q;

  int checks = 0;
  int errors = 0;
  logic [3:0] model_op;

  localparam logic [9:0] F_REQ  = 10'b1000000000;
  localparam logic [9:0] F_WE   = 10'b0100000000;
  localparam logic [9:0] F_ASEL = 10'b0010000000;
  localparam logic [9:0] F_IRL  = 10'b0001000000;
  localparam logic [9:0] F_PCI  = 10'b0000100000;
  localparam logic [9:0] F_PCL  = 10'b0000010000;
  localparam logic [9:0] F_MDR  = 10'b0000001000;
  localparam logic [9:0] F_ALU  = 10'b0000000100;
  localparam logic [9:0] F_RW   = 10'b0000000010;
  localparam logic [9:0] F_ERR  = 10'b0000000001;

  seq_control #(.IW(IW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .run(run), .mem_ack(mem_ack), .instr_in(instr_in),
    .zero_flag(zero_flag), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr_sel(mem_addr_sel), .ir_load(ir_load), .pc_inc(pc_inc),
    .pc_load(pc_load), .mdr_load(mdr_load), .alu_en(alu_en),
    .regwrite_en(regwrite_en), .op_q(op_q), .err(err), .state_q(state_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [12:0] mk(input logic [2:0] st, input logic [9:0] f);
    return {st, f};
  endfunction

  // mem_we / mem_addr_sel are only meaningful while a request is up.
  function automatic logic [12:0] obs_vec();
    return {state_q, mem_req, mem_we & mem_req, mem_addr_sel & mem_req, ir_load, pc_inc,
            pc_load, mdr_load, alu_en, regwrite_en, err};
  endfunction

  // One instruction starting in FETCH; ack codes: 0/1 driven, 2 = random (no request up).
  task automatic run_instr(input logic [3:0] opc, input int fw, input int mw,
                           input logic zf, input string name);
    logic [12:0] eq[$];
    int          aq[$];
    int          ack_idx;
    logic        is_alu, is_lw, is_st, is_bez, is_nop;
    logic [9:0]  mflags;
    logic [12:0] obs;
    logic [3:0]  exp_op;
    is_alu = (opc >= 4'd1) && (opc <= 4'd5);
    is_lw  = (opc == 4'd8);
    is_st  = (opc == 4'd9) || (opc == 4'd10);
    is_bez = (opc == 4'd11);
    is_nop = !(is_alu || is_lw || is_st || is_bez);
    for (int i = 0; i < fw; i++) begin eq.push_back(mk(3'd1, F_REQ)); aq.push_back(0); end
    ack_idx = fw;
    eq.push_back(mk(3'd1, F_REQ | F_IRL | F_PCI)); aq.push_back(1);
    eq.push_back(mk(3'd2, 10'd0)); aq.push_back(2);
    if (!is_nop) begin
      eq.push_back(mk(3'd3, F_ALU | ((is_bez && zf) ? F_PCL : 10'd0))); aq.push_back(2);
      if (is_lw || is_st) begin
        mflags = F_REQ | F_ASEL | (is_st ? F_WE : 10'd0);
        for (int i = 0; i < mw; i++) begin eq.push_back(mk(3'd4, mflags)); aq.push_back(0); end
        eq.push_back(mk(3'd4, mflags | (is_lw ? F_MDR : 10'd0))); aq.push_back(1);
      end
      if (is_alu || is_lw) begin eq.push_back(mk(3'd5, F_RW)); aq.push_back(2); end
    end
    foreach (eq[k]) begin
      @(negedge clk);
      run       = 1'($urandom);
      mem_ack   = (aq[k] == 2) ? 1'($urandom) : aq[k][0];
      instr_in  = (k == ack_idx) ? {opc, 12'($urandom)} : 16'($urandom);
      zero_flag = (eq[k][12:10] == 3'd3) ? zf : 1'($urandom);
      exp_op    = (k > ack_idx) ? opc : model_op;
      #1;
      obs = obs_vec();
      checks++;
      if (obs !== eq[k]) begin
        errors++;
        $display("FAIL %s cycle %0d outputs got %b want %b", name, k, obs, eq[k]);
      end
      checks++;
      if (op_q !== exp_op) begin
        errors++;
        $display("FAIL %s cycle %0d op_q got %b want %b", name, k, op_q, exp_op);
      end
    end
    model_op = opc;
    $display("txn %s op=%b fetch_wait=%0d mem_wait=%0d zf=%0b cycles=%0d",
             name, opc, fw, mw, zf, eq.size());
  endtask

  // Drive run=1 for one IDLE cycle; FETCH must follow.
  task automatic start_from_idle(input string name);
    @(negedge clk);
    run = 1'b1; mem_ack = 1'($urandom);
    #1;
    checks++;
    if (obs_vec() !== mk(3'd0, 10'd0)) begin
      errors++;
      $display("FAIL %s idle got %b want %b", name, obs_vec(), mk(3'd0, 10'd0));
    end
  endtask

  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      rst = 1'b1; run = 1'($urandom); mem_ack = 1'($urandom); instr_in = 16'($urandom);
      #1;
      checks++;
      if ({obs_vec(), op_q, mem_we, mem_addr_sel} !== 19'd0) begin
        errors++;
        $display("FAIL reset got out=%b op=%b we=%b sel=%b want all 0",
                 obs_vec(), op_q, mem_we, mem_addr_sel);
      end
    end
    rst = 1'b0;
    model_op = 4'd0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      run = 1'b0; mem_ack = 1'($urandom);
      #1;
      checks++;
      if (obs_vec() !== mk(3'd0, 10'd0)) begin
        errors++;
        $display("FAIL idle_hold got %b want %b", obs_vec(), mk(3'd0, 10'd0));
      end
    end
    $display("txn reset_and_idle done");
  endtask

  task automatic test_add();
    start_from_idle("add_start");
    run_instr(4'b0001, 0, 0, 1'b0, "add");
  endtask

  task automatic test_lw_wait();
    run_instr(4'b1000, 0, 3, 1'b0, "lw_wait3");
  endtask

  task automatic test_swi_bez();
    run_instr(4'b1010, 0, 0, 1'b0, "swi");
    run_instr(4'b1011, 0, 0, 1'b1, "bez_taken");
    run_instr(4'b1011, 1, 0, 1'b0, "bez_not_taken");
  endtask

  task automatic test_undefined();
    run_instr(4'b1111, 0, 0, 1'b0, "undef_1111");
    run_instr(4'b0000, 2, 0, 1'b1, "nop");
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 40; n++)
      run_instr(4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3),
                1'($urandom), "rand");
  endtask

  task automatic test_timeout();
    logic [12:0] want;
    for (int c = 0; c < TO + 3; c++) begin
      @(negedge clk);
      run = 1'($urandom);
      mem_ack = (c < TO) ? 1'b0 : 1'($urandom);
      instr_in = 16'($urandom);
      #1;
      want = (c < TO) ? mk(3'd1, F_REQ) : mk(3'd7, F_ERR);
      checks++;
      if (obs_vec() !== want || op_q !== model_op) begin
        errors++;
        $display("FAIL timeout cycle %0d got %b op=%b want %b op=%b",
                 c, obs_vec(), op_q, want, model_op);
      end
    end
    $display("txn fetch_timeout halted");
    @(negedge clk);
    rst = 1'b1; run = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    model_op = 4'd0;
    checks++;
    if (obs_vec() !== mk(3'd0, 10'd0) || op_q !== 4'd0) begin
      errors++;
      $display("FAIL halt_reset got %b op=%b want %b op=0000", obs_vec(), op_q, mk(3'd0, 10'd0));
    end
    start_from_idle("expiry_start");
    run_instr(4'b0001, TO - 1, 0, 1'b0, "add_ack_at_expiry");
    run_instr(4'b1001, 0, TO - 1, 1'b0, "sw_ack_at_expiry");
    run_instr(4'b1000, TO - 1, TO - 1, 1'b0, "lw_both_expiry");
  endtask

  task automatic test_reset_mid_mem();
    logic [12:0] want[$];
    logic        rst_seq[$];
    logic        run_seq[$];
    logic [3:0]  op_seq[$];
    logic [12:0] swm;
    swm = mk(3'd4, F_REQ | F_ASEL | F_WE);
    want = '{mk(3'd1, F_REQ | F_IRL | F_PCI), mk(3'd2, 10'd0), mk(3'd3, F_ALU), swm, swm,
             swm, mk(3'd0, 10'd0), mk(3'd0, 10'd0), mk(3'd0, 10'd0), mk(3'd0, 10'd0),
             mk(3'd0, 10'd0), mk(3'd1, F_REQ)};
    rst_seq = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
    run_seq = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0};
    op_seq  = '{model_op, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    foreach (want[k]) begin
      @(negedge clk);
      rst = rst_seq[k];
      run = run_seq[k];
      mem_ack = (k == 0) ? 1'b1 : (want[k][12:10] == 3'd4 ? 1'b0 : 1'($urandom));
      instr_in = (k == 0) ? {4'b1001, 12'($urandom)} : 16'($urandom);
      #1;
      checks++;
      if (obs_vec() !== want[k] || op_q !== op_seq[k]) begin
        errors++;
        $display("FAIL reset_mid_mem cycle %0d got %b op=%b want %b op=%b",
                 k, obs_vec(), op_q, want[k], op_seq[k]);
      end
    end
    rst = 1'b0;
    model_op = 4'd0;
    $display("txn reset_mid_mem sw abandoned");
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; mem_ack = 1'b0; instr_in = '0; zero_flag = 1'b0;
    model_op = 4'd0;
    test_reset();
    test_add();
    test_lw_wait();
    test_swi_bez();
    test_undefined();
    test_back_to_back();
    test_timeout();
    test_reset_mid_mem();
    run_instr(4'b0011, 1, 0, 1'b0, "sub_after_reset");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
